// File: rtl/reg_file_rename_if.sv
// rtl/reg_file_rename_if.sv - commit, rename and operand-query bundle for the renamed register file
interface reg_file_rename_if #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
);
    logic                      cmt_valid;
    logic [REG_NUM_WIDTH-1:0]  cmt_rd;
    logic [31:0]               cmt_value;
    logic [ROB_SIZE_WIDTH-1:0] cmt_rob_id;

    logic                      dec_valid;
    logic [REG_NUM_WIDTH-1:0]  dec_rd;
    logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;
    logic [REG_NUM_WIDTH-1:0]  dec_rs1;
    logic [REG_NUM_WIDTH-1:0]  dec_rs2;

    logic                      rs1_busy_out;
    logic [31:0]               rs1_value_out;
    logic [ROB_SIZE_WIDTH-1:0] rs1_dep_out;
    logic                      rs2_busy_out;
    logic [31:0]               rs2_value_out;
    logic [ROB_SIZE_WIDTH-1:0] rs2_dep_out;

    modport master (
        output cmt_valid, cmt_rd, cmt_value, cmt_rob_id,
        output dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        input  rs1_busy_out, rs1_value_out, rs1_dep_out,
        input  rs2_busy_out, rs2_value_out, rs2_dep_out
    );

    modport slave (
        input  cmt_valid, cmt_rd, cmt_value, cmt_rob_id,
        input  dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        output rs1_busy_out, rs1_value_out, rs1_dep_out,
        output rs2_busy_out, rs2_value_out, rs2_dep_out
    );
endinterface

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
module reg_file_rename #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    reg_file_rename_if.slave  bus
);
    localparam int REG_COUNT = 1 << REG_NUM_WIDTH;

    logic [31:0]               value_q [REG_COUNT];
    logic                      busy_q  [REG_COUNT];
    logic [ROB_SIZE_WIDTH-1:0] tag_q   [REG_COUNT];

    logic cmt_en;
    logic cmt_match;
    logic dec_en;

    assign cmt_en    = bus.cmt_valid && (bus.cmt_rd != '0);
    assign cmt_match = tag_q[bus.cmt_rd] == bus.cmt_rob_id;
    assign dec_en    = bus.dec_valid && (bus.dec_rd != '0) && !flush_in;

    // Later assignments win: flush clears every busy bit after the commit,
    // and a same-cycle rename overrides the commit's busy clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (cmt_en) begin
                value_q[bus.cmt_rd] <= bus.cmt_value;
                if (cmt_match) begin
                    busy_q[bus.cmt_rd] <= 1'b0;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    busy_q[i] <= 1'b0;
                end
            end else if (dec_en) begin
                busy_q[bus.dec_rd] <= 1'b1;
                tag_q[bus.dec_rd]  <= bus.dec_rob_id;
            end
        end
    end

    logic [REG_NUM_WIDTH-1:0]  q_idx   [2];
    logic                      q_busy  [2];
    logic [31:0]               q_value [2];
    logic [ROB_SIZE_WIDTH-1:0] q_dep   [2];

    assign q_idx[0] = bus.dec_rs1;
    assign q_idx[1] = bus.dec_rs2;

    // A commit that retires the producer a source waits on is forwarded
    // immediately so the decoder never sees a stale busy bit.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_busy[p]  = 1'b0;
            q_value[p] = '0;
            q_dep[p]   = '0;
            if (q_idx[p] != '0) begin
                q_dep[p] = tag_q[q_idx[p]];
                if (bus.cmt_valid && (bus.cmt_rd == q_idx[p]) && busy_q[q_idx[p]]
                    && (tag_q[q_idx[p]] == bus.cmt_rob_id)) begin
                    q_value[p] = bus.cmt_value;
                end else begin
                    q_busy[p]  = busy_q[q_idx[p]];
                    q_value[p] = value_q[q_idx[p]];
                end
            end
        end
    end

    assign bus.rs1_busy_out  = q_busy[0];
    assign bus.rs1_value_out = q_value[0];
    assign bus.rs1_dep_out   = q_dep[0];
    assign bus.rs2_busy_out  = q_busy[1];
    assign bus.rs2_value_out = q_value[1];
    assign bus.rs2_dep_out   = q_dep[1];
endmodule
